// File: rtl/mem_arbiter_pkg.sv
// Shared types and sizing for the main-memory arbiter between the I-cache fill,
// D-cache fill and D-cache store paths.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_IFILL = 2'd1,
    ST_DFILL = 2'd2,
    ST_DRAIN = 2'd3
  } arb_state_e;

  localparam int WORDS   = 8;
  localparam int MAX_OUT = 4;
  localparam int CNT_W   = 4;

  localparam logic [CNT_W-1:0] WORDS_C   = CNT_W'(WORDS);
  localparam logic [CNT_W-1:0] MAX_OUT_C = CNT_W'(MAX_OUT);

endpackage

// File: rtl/mem_arbiter_counter.sv
// Small up/down counter with synchronous clear; an increment and a decrement in
// the same cycle cancel out.
module arb_counter
  import mem_arbiter_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] count_o
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && !dec_i) begin
      count_d = count_q + 1'b1;
    end else if (dec_i && !inc_i) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/mem_arbiter.sv
// Main-memory arbiter: stores issue from IDLE, a cache fill owns memory until its
// miss drops, and in-flight reads are drained before anyone is granted again.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_miss,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_mem_en,
  input  logic              d_miss,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic              d_mem_en,
  input  logic              d_wr_req,
  input  logic [ADDR_W-1:0] d_wr_addr,
  input  logic [DATA_W-1:0] d_wr_data,
  output logic              i_grant,
  output logic              d_grant,
  output logic              i_data_valid,
  output logic              d_data_valid,
  output logic [DATA_W-1:0] fill_data,
  output logic              d_wr_ack,
  output logic              arb_busy,
  output logic              mem_enable,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rvalid,
  output logic [1:0]        dbg_state
);

  arb_state_e       state_q, state_d;
  logic [CNT_W-1:0] beat_q, out_q, out_next;
  logic             in_fill, owner_miss, owner_en, issue, rd_ret, beat_ok, beat_inc, cnt_clr;
  logic [ADDR_W-1:0] owner_addr;

  always_comb begin
    in_fill    = (state_q == ST_IFILL) || (state_q == ST_DFILL);
    owner_miss = (state_q == ST_DFILL) ? d_miss   : i_miss;
    owner_en   = (state_q == ST_DFILL) ? d_mem_en : i_mem_en;
    owner_addr = (state_q == ST_DFILL) ? d_addr   : i_addr;
    // The exit cycle issues nothing, so outstanding reads can only shrink from here.
    issue      = in_fill && owner_miss && owner_en && (out_q < MAX_OUT_C);
    rd_ret     = mem_rvalid && (state_q != ST_IDLE);
    out_next   = out_q + CNT_W'(issue) - CNT_W'(rd_ret);
    beat_ok    = in_fill && mem_rvalid && (beat_q < WORDS_C);
    beat_inc   = beat_ok;
  end

  always_comb begin
    state_d      = state_q;
    mem_enable   = 1'b0;
    mem_wr       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    d_wr_ack     = 1'b0;
    i_grant      = 1'b0;
    d_grant      = 1'b0;
    i_data_valid = 1'b0;
    d_data_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (d_wr_req) begin
          mem_enable = 1'b1;
          mem_wr     = 1'b1;
          mem_addr   = d_wr_addr;
          mem_wdata  = d_wr_data;
          d_wr_ack   = 1'b1;
        end else if (d_miss) begin
          state_d = ST_DFILL;
        end else if (i_miss) begin
          state_d = ST_IFILL;
        end
      end
      ST_IFILL, ST_DFILL: begin
        if (owner_miss) begin
          i_grant    = (state_q == ST_IFILL);
          d_grant    = (state_q == ST_DFILL);
          mem_enable = issue;
          mem_addr   = owner_addr;
        end else begin
          state_d = (out_next == '0) ? ST_IDLE : ST_DRAIN;
        end
        i_data_valid = beat_ok && (state_q == ST_IFILL);
        d_data_valid = beat_ok && (state_q == ST_DFILL);
      end
      ST_DRAIN: begin
        if (out_next == '0) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign cnt_clr   = (state_d == ST_IDLE) && (state_q != ST_IDLE);
  assign fill_data = mem_rdata;
  assign arb_busy  = (state_q != ST_IDLE);
  assign dbg_state = state_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  arb_counter u_beat_cnt (
    .clk_i   (clk),
    .rst_i   (rst),
    .clr_i   (cnt_clr),
    .inc_i   (beat_inc),
    .dec_i   (1'b0),
    .count_o (beat_q)
  );

  arb_counter u_out_cnt (
    .clk_i   (clk),
    .rst_i   (rst),
    .clr_i   (cnt_clr),
    .inc_i   (issue),
    .dec_i   (rd_ret),
    .count_o (out_q)
  );

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: fixed-latency memory model, owner-level reference model
// compared every cycle, directed scenarios with literal expectations, then random episodes.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int AW = 16;
  localparam int DW = 16;
  localparam int LAT = 4;
  localparam int M_IDLE = 0, M_IFILL = 1, M_DFILL = 2, M_DRAIN = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_miss, i_mem_en, d_miss, d_mem_en, d_wr_req;
  logic [AW-1:0] i_addr, d_addr, d_wr_addr, mem_addr;
  logic [DW-1:0] d_wr_data, fill_data, mem_wdata, mem_rdata;
  logic          i_grant, d_grant, i_data_valid, d_data_valid, d_wr_ack, arb_busy;
  logic          mem_enable, mem_wr, mem_rvalid;
  logic [1:0]    dbg_state;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .i_miss(i_miss), .i_addr(i_addr), .i_mem_en(i_mem_en),
    .d_miss(d_miss), .d_addr(d_addr), .d_mem_en(d_mem_en),
    .d_wr_req(d_wr_req), .d_wr_addr(d_wr_addr), .d_wr_data(d_wr_data),
    .i_grant(i_grant), .d_grant(d_grant),
    .i_data_valid(i_data_valid), .d_data_valid(d_data_valid),
    .fill_data(fill_data), .d_wr_ack(d_wr_ack), .arb_busy(arb_busy),
    .mem_enable(mem_enable), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
    .dbg_state(dbg_state)
  );

  int n_checks = 0, n_pass = 0, cyc = 0;
  int due_q[$];
  logic [DW-1:0] exp_q[$];
  int m_mode = M_IDLE, m_out = 0, m_beat = 0;
  logic m_last_issue, m_last_iv, m_last_dv;
  logic obs_en, obs_wr, obs_ack, obs_ig, obs_dg, obs_iv, obs_dv, obs_busy;
  logic [AW-1:0] obs_addr, first_addr;
  logic [DW-1:0] obs_wd;
  bit got_first;
  int cnt_iv, cnt_dv, cnt_ack, cnt_rv, cnt_busy, cnt_ig;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic clr_cnt();
    cnt_iv = 0; cnt_dv = 0; cnt_ack = 0; cnt_rv = 0; cnt_busy = 0; cnt_ig = 0; got_first = 0;
  endtask

  task automatic cycle();
    logic rv, e_en, e_wr, e_ack, e_ig, e_dg, e_iv, e_dv, e_busy;
    logic fill_now, issue, ret, own_miss, own_en, ack_seen;
    logic [AW-1:0] e_addr, own_addr;
    logic [DW-1:0] rd, e_wd;
    int n_out;
    rv = 1'b0;
    rd = DW'($urandom);
    if (due_q.size() > 0 && due_q[0] == cyc) begin
      rv = 1'b1;
      rd = exp_q.pop_front();
      void'(due_q.pop_front());
    end
    mem_rvalid = rv;
    mem_rdata  = rd;
    if (rst) begin m_mode = M_IDLE; m_out = 0; m_beat = 0; end
    {e_en, e_wr, e_ack, e_ig, e_dg, e_iv, e_dv} = '0;
    e_addr = '0; e_wd = '0;
    e_busy   = (m_mode != M_IDLE);
    fill_now = (m_mode == M_IFILL) || (m_mode == M_DFILL);
    own_miss = (m_mode == M_DFILL) ? d_miss : i_miss;
    own_en   = (m_mode == M_DFILL) ? d_mem_en : i_mem_en;
    own_addr = (m_mode == M_DFILL) ? d_addr : i_addr;
    if (m_mode == M_IDLE && d_wr_req) begin
      e_en = 1; e_wr = 1; e_ack = 1; e_addr = d_wr_addr; e_wd = d_wr_data;
    end
    if (fill_now && own_miss) begin
      e_ig = (m_mode == M_IFILL);
      e_dg = (m_mode == M_DFILL);
      e_en = own_en && (m_out < MAX_OUT);
      e_addr = own_addr;
    end
    if (fill_now && rv && m_beat < WORDS) begin
      e_iv = (m_mode == M_IFILL);
      e_dv = (m_mode == M_DFILL);
    end
    issue = e_en && !e_wr;
    #3;
    chk("i_grant", i_grant, e_ig);
    chk("d_grant", d_grant, e_dg);
    chk("i_data_valid", i_data_valid, e_iv);
    chk("d_data_valid", d_data_valid, e_dv);
    chk("d_wr_ack", d_wr_ack, e_ack);
    chk("arb_busy", arb_busy, e_busy);
    chk("mem_enable", mem_enable, e_en);
    chk("mem_wr", mem_wr, e_wr);
    if (e_en) chk("mem_addr", mem_addr, e_addr);
    if (e_wr) chk("mem_wdata", mem_wdata, e_wd);
    if (rv) chk("fill_data", fill_data, rd);
    obs_en = mem_enable; obs_wr = mem_wr; obs_ack = d_wr_ack; obs_ig = i_grant; obs_dg = d_grant;
    obs_iv = i_data_valid; obs_dv = d_data_valid; obs_busy = arb_busy;
    obs_addr = mem_addr; obs_wd = mem_wdata;
    if (obs_iv) cnt_iv++;
    if (obs_dv) cnt_dv++;
    if (obs_ack) cnt_ack++;
    if (obs_busy) cnt_busy++;
    if (obs_ig) cnt_ig++;
    if (rv) cnt_rv++;
    if (obs_en && !obs_wr && !got_first) begin got_first = 1; first_addr = obs_addr; end
    if (!rst) begin
      ret = rv && (m_mode != M_IDLE);
      if (issue) begin
        due_q.push_back(cyc + LAT);
        exp_q.push_back(DW'($urandom));
      end
      n_out = m_out + int'(issue) - int'(ret);
      if (fill_now && rv && m_beat < WORDS) m_beat++;
      case (m_mode)
        M_IDLE: if (!d_wr_req) begin
          if (d_miss) m_mode = M_DFILL;
          else if (i_miss) m_mode = M_IFILL;
        end
        M_IFILL, M_DFILL: if (!own_miss) m_mode = (n_out == 0) ? M_IDLE : M_DRAIN;
        default: if (n_out == 0) m_mode = M_IDLE;
      endcase
      m_out = n_out;
      if (m_mode == M_IDLE) begin m_out = 0; m_beat = 0; end
    end
    m_last_issue = issue; m_last_iv = e_iv; m_last_dv = e_dv;
    ack_seen = obs_ack;
    @(posedge clk);
    #1;
    cyc++;
    if (ack_seen) d_wr_req = 1'b0;
  endtask

  task automatic fill(input bit is_d, input logic [AW-1:0] base, input int stop_iss,
                      input int stop_beats, input bit rnd, output int lat);
    int issued, beats;
    bit done, en;
    issued = 0; beats = 0; lat = -1; done = 0;
    if (is_d) d_miss = 1; else i_miss = 1;
    for (int k = 0; k < 300 && !done; k++) begin
      en = (issued < stop_iss) && (!rnd || $urandom_range(0, 3) != 0);
      if (is_d) begin d_mem_en = en; d_addr = base + AW'(issued); end
      else begin i_mem_en = en; i_addr = base + AW'(issued); end
      cycle();
      if (lat < 0 && (is_d ? obs_dg : obs_ig)) lat = k;
      if (m_last_issue) issued++;
      if (is_d ? m_last_dv : m_last_iv) beats++;
      done = (issued >= stop_iss) && (beats >= stop_beats);
    end
    chk("fill_done", done, 1'b1);
    if (is_d) d_mem_en = 0; else i_mem_en = 0;
  endtask

  task automatic drop(input bit is_d, output int n);
    if (is_d) begin d_miss = 0; d_mem_en = 0; end
    else begin i_miss = 0; i_mem_en = 0; end
    n = 0;
    do begin
      cycle();
      n++;
    end while (m_mode != M_IDLE && n < 50);
    chk("drop_reaches_idle", m_mode, M_IDLE);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, n;
    rst = 1; i_miss = 0; i_mem_en = 0; d_miss = 0; d_mem_en = 0; d_wr_req = 0;
    i_addr = '0; d_addr = '0; d_wr_addr = '0; d_wr_data = '0;
    mem_rvalid = 0; mem_rdata = '0;
    clr_cnt();
    @(posedge clk); #1;
    cycle();
    chk("rst_busy", obs_busy, 0);
    chk("rst_mem_enable", obs_en, 0);
    chk("rst_grants", {obs_ig, obs_dg}, 0);
    rst = 0;
    cycle();

    // I-cache fill alone
    clr_cnt();
    fill(0, 16'h1230, 8, 8, 0, lat);
    chk("i_lat", lat, 1);
    chk("i_first_addr", first_addr, 16'h1230);
    drop(0, n);
    chk("i_exit_cycles", n, 1);
    chk("i_beats", cnt_iv, 8);
    chk("i_no_d_valid", cnt_dv, 0);

    // store in IDLE
    d_wr_req = 1; d_wr_addr = 16'h4002; d_wr_data = 16'hBEEF;
    cycle();
    chk("wr_mem_wr", obs_wr, 1);
    chk("wr_addr", obs_addr, 16'h4002);
    chk("wr_data", obs_wd, 16'hBEEF);
    chk("wr_ack", obs_ack, 1);
    cycle();
    chk("wr_ack_pulse", obs_ack, 0);

    // simultaneous misses: D first, then I after the bubble
    clr_cnt();
    i_miss = 1;
    fill(1, 16'h2000, 8, 8, 0, lat);
    chk("prio_d_lat", lat, 1);
    drop(1, n);
    chk("prio_d_exit", n, 1);
    chk("prio_no_i_grant", cnt_ig, 0);
    fill(0, 16'h3000, 8, 8, 1, lat);
    chk("prio_i_lat", lat, 1);
    drop(0, n);

    // store held off during IFILL, then beats a pending D miss
    clr_cnt();
    fill(0, 16'h5000, 8, 4, 0, lat);
    d_wr_req = 1; d_wr_addr = 16'h5A5A; d_wr_data = 16'h1234; d_miss = 1;
    fill(0, 16'h5008, 0, 4, 0, lat);
    drop(0, n);
    chk("wr_held_in_fill", cnt_ack, 0);
    cycle();
    chk("wr_after_fill_ack", obs_ack, 1);
    chk("wr_after_fill_addr", obs_addr, 16'h5A5A);
    fill(1, 16'h5100, 8, 8, 0, lat);
    chk("d_after_wr_lat", lat, 1);
    drop(1, n);

    // drain with 3 outstanding, waiting I miss granted afterwards
    fill(1, 16'h6000, 3, 0, 0, lat);
    i_miss = 1;
    clr_cnt();
    drop(1, n);
    chk("drain_cycles", n, 4);
    chk("drain_swallowed_rv", cnt_rv, 3);
    chk("drain_no_valid", cnt_iv + cnt_dv, 0);
    fill(0, 16'h7000, 8, 8, 0, lat);
    chk("post_drain_i_lat", lat, 1);
    drop(0, n);

    // beats beyond WORDS are suppressed
    clr_cnt();
    fill(0, 16'h7800, 10, 8, 0, lat);
    repeat (6) cycle();
    drop(0, n);
    chk("extra_beats_rv", cnt_rv, 10);
    chk("extra_beats_valid", cnt_iv, 8);

    // async reset mid-DFILL with 2 outstanding
    fill(1, 16'h8000, 2, 0, 0, lat);
    clr_cnt();
    rst = 1; d_miss = 0;
    cycle();
    chk("rst_mid_busy", obs_busy, 0);
    chk("rst_mid_d_grant", obs_dg, 0);
    rst = 0;
    repeat (6) cycle();
    chk("rst_late_rv", cnt_rv, 2);
    chk("rst_late_valid", cnt_iv + cnt_dv, 0);
    clr_cnt();
    fill(0, 16'h9000, 8, 8, 1, lat);
    drop(0, n);
    chk("post_rst_beats", cnt_iv, 8);

    // random episodes
    for (int ep = 0; ep < 40; ep++) begin
      bit is_d;
      int si, sb;
      is_d = 1'($urandom_range(0, 1));
      si = $urandom_range(1, 10);
      sb = $urandom_range(0, (si < WORDS) ? si : WORDS);
      i_addr = AW'($urandom); d_addr = AW'($urandom);
      if ($urandom_range(0, 2) == 0) begin
        d_wr_req = 1; d_wr_addr = AW'($urandom); d_wr_data = DW'($urandom);
      end
      fill(is_d, AW'($urandom), si, sb, 1, lat);
      if ($urandom_range(0, 2) == 0) begin
        d_wr_req = 1; d_wr_addr = AW'($urandom); d_wr_data = DW'($urandom);
      end
      if ($urandom_range(0, 2) == 0) begin
        if (is_d) i_miss = 1; else d_miss = 1;
      end
      repeat ($urandom_range(0, 3)) cycle();
      drop(is_d, n);
      i_miss = 0; d_miss = 0;
      repeat ($urandom_range(1, 3)) cycle();
    end
    repeat (8) cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
